// File: rtl/life_hud_renderer_pkg.sv
// life_hud_renderer_pkg: shared sprite geometry, transparent key, FSM encodings
// and the heart bitmap used by the heart sprite ROMs.
package life_hud_renderer_pkg;

  localparam int          SPRITE_W   = 14;
  localparam int          SPRITE_H   = 10;
  localparam logic [7:0]  TRANSP_KEY = 8'hBB;

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } life_state_e;

  // Heart outline, one word per row, column 0 is the MSB.
  localparam logic [13:0] HEART_MASK [SPRITE_H] = '{
    14'b00111100111100,
    14'b01111111111110,
    14'b11111111111111,
    14'b11111111111111,
    14'b01111111111110,
    14'b00111111111100,
    14'b00011111111000,
    14'b00001111110000,
    14'b00000111100000,
    14'b00000011000000
  };

  // Full hearts are red, empty hearts grey; low bits carry the column so an
  // address slip shows up as a colour change.
  function automatic logic [7:0] heart_texel(input logic [3:0] row,
                                             input logic [3:0] col,
                                             input logic       full);
    logic [13:0] line;
    if (row >= 4'(SPRITE_H) || col >= 4'(SPRITE_W)) return TRANSP_KEY;
    line = HEART_MASK[row];
    if (!line[4'(SPRITE_W - 1) - col]) return TRANSP_KEY;
    return full ? {5'b11100, col[2:0]} : {5'b01001, col[2:0]};
  endfunction

endpackage

// File: rtl/life_hud_renderer_heart_rom.sv
// life_hud_renderer_heart_rom: 14x10 RGB332 heart sprite ROM (full or empty
// variant). Address is registered internally: data appears 1 clk later.
//   clk        in  clock
//   row, col   in  sprite address
//   data       out texel, TRANSP_KEY outside the heart shape
module life_hud_renderer_heart_rom
  import life_hud_renderer_pkg::*;
#(
  parameter logic FULL = 1'b1
)(
  input  logic       clk,
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic [7:0] data
);
  logic [7:0] data_d, data_q;

  assign data_d = heart_texel(row, col, FULL);

  always_ff @(posedge clk) data_q <= data_d;

  assign data = data_q;
endmodule

// File: rtl/life_hud_renderer_life_counter.sv
// life_counter: lives count plus ALIVE/INVULN/DEAD FSM with invulnerability
// frame counter.
//   clk, reset           clock, synchronous active-high reset
//   hit, extra_life      1-clk event pulses
//   game_restart         1-clk pulse, overrides everything
//   frame_tick           1-clk pulse once per frame
//   lives, state         current lives and FSM state
//   inv_cnt              remaining invulnerability frames
//   game_over            high while lives == 0
module life_counter
  import life_hud_renderer_pkg::*;
#(
  parameter int MAX_LIVES   = 3,
  parameter int START_LIVES = 3,
  parameter int INVULN_FRM  = 60
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       hit,
  input  logic       extra_life,
  input  logic       game_restart,
  input  logic       frame_tick,
  output logic [2:0] lives,
  output logic [1:0] state,
  output logic [7:0] inv_cnt,
  output logic       game_over
);
  localparam logic [2:0] LIVES_MAX  = 3'(MAX_LIVES);
  localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);
  localparam logic [7:0] INV_LOAD   = 8'(INVULN_FRM);

  life_state_e state_d, state_q;
  logic [2:0]  lives_d, lives_q;
  logic [7:0]  inv_cnt_d, inv_cnt_q;
  logic        game_over_d, game_over_q;

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    inv_cnt_d   = inv_cnt_q;
    game_over_d = game_over_q;
    if (game_restart) begin
      state_d     = ST_ALIVE;
      lives_d     = LIVES_INIT;
      inv_cnt_d   = '0;
      game_over_d = 1'b0;
    end else begin
      case (state_q)
        ST_ALIVE: begin
          if (hit) begin
            inv_cnt_d = INV_LOAD;
            if (extra_life) begin
              // pickup in the same cycle cancels the loss, still invulnerable
              state_d = ST_INVULN;
            end else if (lives_q <= 3'd1) begin
              lives_d     = '0;
              state_d     = ST_DEAD;
              game_over_d = 1'b1;
            end else begin
              lives_d = lives_q - 3'd1;
              state_d = ST_INVULN;
            end
          end else if (extra_life && lives_q < LIVES_MAX) begin
            lives_d = lives_q + 3'd1;
          end
        end
        ST_INVULN: begin
          if (extra_life && lives_q < LIVES_MAX) lives_d = lives_q + 3'd1;
          if (frame_tick) begin
            if (inv_cnt_q <= 8'd1) begin
              inv_cnt_d = '0;
              state_d   = ST_ALIVE;
            end else begin
              inv_cnt_d = inv_cnt_q - 8'd1;
            end
          end
        end
        default: ;  // DEAD: only game_restart leaves
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ALIVE;
      lives_q     <= LIVES_INIT;
      inv_cnt_q   <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      inv_cnt_q   <= inv_cnt_d;
      game_over_q <= game_over_d;
    end
  end

  assign lives     = lives_q;
  assign state     = state_q;
  assign inv_cnt   = inv_cnt_q;
  assign game_over = game_over_q;
endmodule

// File: rtl/life_hud_renderer.sv
// life_hud_renderer: draws MAX_LIVES heart slots at (HUD_X,HUD_Y), full for
// remaining lives, empty otherwise, with the lost heart blinking while
// invulnerable. x/y to life_on/rgb_out latency is 2 clk.
//   clk, reset              pixel clock, synchronous active-high reset
//   video_on, x, y          raster position from vga_sync
//   hit/extra_life/game_restart  gameplay event pulses
//   heart_row, heart_col    address to both heart ROMs (0 outside slots)
//   full_color/empty_color  ROM data, 1 clk after the address
//   lives, game_over        life state
//   life_on, rgb_out        HUD pixel opaque flag and colour
module life_hud_renderer
  import life_hud_renderer_pkg::*;
#(
  parameter int         MAX_LIVES   = 3,
  parameter int         START_LIVES = 3,
  parameter int         HUD_X       = 16,
  parameter int         HUD_Y       = 8,
  parameter int         HEART_W     = SPRITE_W,
  parameter int         HEART_H     = SPRITE_H,
  parameter int         HEART_GAP   = 4,
  parameter int         INVULN_FRM  = 60,
  parameter logic [7:0] TRANSP      = TRANSP_KEY
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       video_on,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       hit,
  input  logic       extra_life,
  input  logic       game_restart,
  output logic [3:0] heart_row,
  output logic [3:0] heart_col,
  input  logic [7:0] full_color,
  input  logic [7:0] empty_color,
  output logic [2:0] lives,
  output logic       game_over,
  output logic       life_on,
  output logic [7:0] rgb_out
);
  localparam int PITCH = HEART_W + HEART_GAP;

  logic                         frame_tick_d, frame_tick_q;
  logic [1:0]                   state;
  logic [7:0]                   inv_cnt;
  logic                         y_in;
  logic [MAX_LIVES-1:0]         slot_hit;
  logic [MAX_LIVES-1:0][9:0]    slot_left;
  logic                         any_slot;
  logic [2:0]                   slot_idx;
  logic [9:0]                   cur_left;
  logic                         blink;
  logic                         in_heart_d, in_heart_q;
  logic                         use_full_d, use_full_q;
  logic [7:0]                   sel;
  logic                         life_on_d, life_on_q;
  logic [7:0]                   rgb_d, rgb_q;
  logic                         unused_inv_bits;

  life_counter #(
    .MAX_LIVES  (MAX_LIVES),
    .START_LIVES(START_LIVES),
    .INVULN_FRM (INVULN_FRM)
  ) u_life_counter (
    .clk         (clk),
    .reset       (reset),
    .hit         (hit),
    .extra_life  (extra_life),
    .game_restart(game_restart),
    .frame_tick  (frame_tick_q),
    .lives       (lives),
    .state       (state),
    .inv_cnt     (inv_cnt),
    .game_over   (game_over)
  );

  // Only bit 3 drives the blink phase.
  assign unused_inv_bits = ^{inv_cnt[7:4], inv_cnt[2:0]};

  assign frame_tick_d = (x == 10'd0) && (y == 10'd0);

  // Stage 0: one range comparator pair per slot, shared row window.
  assign y_in = ({1'b0, y} >= 11'(HUD_Y)) && ({1'b0, y} < 11'(HUD_Y + HEART_H));

  for (genvar k = 0; k < MAX_LIVES; k++) begin : g_slot
    localparam logic [10:0] LEFT = 11'(HUD_X + k * PITCH);
    assign slot_left[k] = LEFT[9:0];
    assign slot_hit[k]  = y_in && ({1'b0, x} >= LEFT) && ({1'b0, x} < LEFT + 11'(HEART_W));
  end

  always_comb begin
    any_slot = 1'b0;
    slot_idx = '0;
    cur_left = '0;
    for (int k = 0; k < MAX_LIVES; k++) begin
      if (slot_hit[k]) begin
        any_slot = 1'b1;
        slot_idx = 3'(k);
        cur_left = slot_left[k];
      end
    end
  end

  assign heart_row = any_slot ? 4'(y - 10'(HUD_Y)) : 4'd0;
  assign heart_col = any_slot ? 4'(x - cur_left)   : 4'd0;

  // The first lost heart flashes while invulnerable.
  assign blink      = (state == ST_INVULN) && (slot_idx == lives) && inv_cnt[3];
  assign in_heart_d = any_slot && video_on;
  assign use_full_d = (slot_idx < lives) || blink;

  // Stage 2: stage-1 flags are aligned with ROM data here.
  assign sel       = use_full_q ? full_color : empty_color;
  assign life_on_d = in_heart_q && (sel != TRANSP);
  assign rgb_d     = life_on_d ? sel : 8'h00;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_tick_q <= 1'b0;
      in_heart_q   <= 1'b0;
      use_full_q   <= 1'b0;
      life_on_q    <= 1'b0;
      rgb_q        <= '0;
    end else begin
      frame_tick_q <= frame_tick_d;
      in_heart_q   <= in_heart_d;
      use_full_q   <= use_full_d;
      life_on_q    <= life_on_d;
      rgb_q        <= rgb_d;
    end
  end

  assign life_on = life_on_q;
  assign rgb_out = rgb_q;
endmodule
